regfile_md: RTL
===============

# regfile_md

Parametrised register file with an integrated multiply/divide unit and HI/LO register pair. It supplies two combinational read ports, one write port and a debug read port for the datapath. A start/busy handshake drives an iterative signed/unsigned multiplier and divider whose results land in HI/LO. It replaces the fixed 32×32 file with its single-cycle HI/LO load, and sits between decode (operand read) and writeback.

## Interface
Parameters:
- DATA_W, 32, register/operand width (≥ 2)
- ADDR_W, 5, register address width; file holds 2**ADDR_W registers

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- rs_addr  in  ADDR_W  read port A address
- rt_addr  in  ADDR_W  read port B address
- rs_data  out  DATA_W  read port A data (combinational)
- rt_data  out  DATA_W  read port B data (combinational)
- wr_en  in  1  register write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (combinational, no bypass)
- hilo_we  in  1  move-to-HI/LO enable
- hilo_sel  in  1  0 = LO, 1 = HI
- md_start  in  1  start multiply/divide
- md_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- md_a, md_b  in  DATA_W  operands (dividend, divisor for DIV)
- md_busy  out  1  operation in flight
- hi_out, lo_out  out  DATA_W  HI/LO contents

## Operation
- Register 0 reads as 0 on all ports; writes to it are discarded.
- Reads: if wr_en && wr_addr == rs_addr/rt_addr && addr ≠ 0, the port returns wr_data (write-through bypass). dbg_data shows stored contents only.
- hilo_we writes wr_data to HI or LO per hilo_sel, independent of wr_en. It is ignored while md_busy = 1; the pipeline stalls instead.
- md_start is accepted only when md_busy = 0. While busy it is ignored; operands are not re-sampled.
- FSM states:
  - IDLE: on md_start, latch op and operand magnitudes (signed ops take the absolute value), record sign flags, then go to CALC.
  - CALC: DATA_W iterations. MULT uses shift-add on the 2·DATA_W product; DIV uses restoring shift-subtract. After the last iteration go to FIX.
  - FIX: apply signs and write HI/LO, then go to IDLE.
- Results:
  - MULT/MULTU: {HI, LO} = full 2·DATA_W product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the dividend's sign.
- Divide by zero: LO = all ones, HI = dividend (original signed value for DIV).
- Signed overflow (DIV of −2**(DATA_W−1) by −1): LO = −2**(DATA_W−1), HI = 0.
- A register write (wr_en) proceeds normally during a busy operation.

## Timing
- Reset: all registers, HI, LO = 0; md_busy = 0; FSM = IDLE. Reset during CALC/FIX aborts with no HI/LO write.
- Register file write latency: 1 edge. Bypass makes the data visible on read ports in the same cycle.
- md_start sampled at edge E0 → md_busy = 1 after E0.
- md_busy stays high for DATA_W + 1 cycles (33 at DATA_W = 32).
- HI/LO updated and md_busy cleared at edge E(DATA_W + 1). A new md_start is accepted in that same following cycle.
- hi_out/lo_out change only on hilo_we or at FIX.

## Structure
- Package regfile_md_pkg holds:
  - md_op encoding (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
  - FSM state enum (IDLE, CALC, FIX)
- Sub-module md_iter_unit holds the FSM, iteration counter ($clog2(DATA_W + 1) bits), sign handling and special cases.
- regfile_md owns the register array, bypass logic and HI/LO registers; it instantiates md_iter_unit.

## Test plan
- Write r5 = 0x1234_5678 while reading rs_addr = 5 in the same cycle → rs_data = 0x1234_5678 that cycle; dbg_data(5) = 0 until the next cycle.
- Write r0 = 0xFFFF_FFFF → rs_data/rt_data/dbg_data for address 0 = 0.
- MULT md_a = 0xFFFF_FFFE (−2), md_b = 3 → busy for 33 cycles, then HI = 0xFFFF_FFFF, LO = 0xFFFF_FFFA. MULTU with the same operands → HI = 0x0000_0002, LO = 0xFFFF_FFFA.
- DIV −7 / 2 → LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF. DIVU 7 / 0 → LO = 0xFFFF_FFFF, HI = 7. DIV 0x8000_0000 / −1 → LO = 0x8000_0000, HI = 0.
- During busy: second md_start and hilo_we (LO ← 0xAA) → both ignored; the first result is written unchanged.
- Assert rst in cycle 10 of a MULTU → md_busy = 0, HI = LO = 0 next cycle, no later write.

Source files
------------

// File: rtl/regfile_md_pkg.sv
// Shared encodings for the register file and its multiply/divide unit.
package regfile_md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_iter_unit.sv
// Iterative shift-add multiplier / restoring divider working on operand magnitudes,
// with sign fix-up and divide special cases applied in the FIX state.
module md_iter_unit
    import regfile_md_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  md_op_e            i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output md_state_e         o_state
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_NEG   = {1'b1, {(DATA_W-1){1'b0}}};

    md_state_e         r_state, w_state_next;
    md_op_e            r_op;
    logic              r_sa, r_sb;
    logic [DATA_W-1:0] r_acc, r_q, r_b, r_a_orig;
    logic [CNT_W-1:0]  r_cnt;

    logic                w_sgn_a, w_sgn_b, w_is_div, w_div0, w_ovf;
    logic [DATA_W-1:0]   w_mag_a, w_mag_b;
    logic [DATA_W:0]     w_mul_sum, w_div_shift, w_div_diff;
    logic [2*DATA_W-1:0] w_prod;

    assign w_sgn_a  = md_is_signed(i_op) & i_a[DATA_W-1];
    assign w_sgn_b  = md_is_signed(i_op) & i_b[DATA_W-1];
    assign w_mag_a  = w_sgn_a ? -i_a : i_a;
    assign w_mag_b  = w_sgn_b ? -i_b : i_b;
    assign w_is_div = md_is_div(r_op);

    // Multiply: {acc, q} shifts right, acc gathers the partial product (carry in bit DATA_W).
    assign w_mul_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
    // Divide: remainder in acc, dividend bits shift out of q's MSB, quotient bits shift in.
    assign w_div_shift = {r_acc, r_q[DATA_W-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_b};

    assign w_div0 = (r_b == '0);
    assign w_ovf  = (r_op == MD_DIV) && (r_a_orig == MIN_NEG) && r_sb && (r_b == DATA_W'(1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_next = CALC;
            CALC:    if (r_cnt == LAST_ITER) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= MD_MULT;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_a_orig <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_op     <= i_op;
                    r_sa     <= w_sgn_a;
                    r_sb     <= w_sgn_b;
                    r_a_orig <= i_a;
                    r_b      <= w_mag_b;
                    r_acc    <= '0;
                    r_q      <= w_mag_a;
                    r_cnt    <= '0;
                end
                CALC: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_is_div) begin
                        if (!w_div_diff[DATA_W]) begin
                            r_acc <= w_div_diff[DATA_W-1:0];
                            r_q   <= {r_q[DATA_W-2:0], 1'b1};
                        end else begin
                            r_acc <= w_div_shift[DATA_W-1:0];
                            r_q   <= {r_q[DATA_W-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= w_mul_sum[DATA_W:1];
                        r_q   <= {w_mul_sum[0], r_q[DATA_W-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_prod = {r_acc, r_q};
        o_hi   = '0;
        o_lo   = '0;
        if (!w_is_div) begin
            if (r_sa ^ r_sb) w_prod = -w_prod;
            o_hi = w_prod[2*DATA_W-1:DATA_W];
            o_lo = w_prod[DATA_W-1:0];
        end else if (w_div0) begin
            o_lo = '1;
            o_hi = r_a_orig;
        end else if (w_ovf) begin
            o_lo = MIN_NEG;
            o_hi = '0;
        end else begin
            // Quotient truncates toward zero; remainder follows the dividend's sign.
            o_lo = (r_sa ^ r_sb) ? -r_q : r_q;
            o_hi = r_sa ? -r_acc : r_acc;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/regfile_md.sv
// Register file with write-through read ports, HI/LO pair and an iterative mul/div unit.
// md_start is taken only while md_busy is low; md_busy falls on the edge that writes HI/LO.
module regfile_md
    import regfile_md_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              hilo_we,
    input  logic              hilo_sel,
    input  logic              md_start,
    input  logic [1:0]        md_op,
    input  logic [DATA_W-1:0] md_a,
    input  logic [DATA_W-1:0] md_b,
    output logic              md_busy,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);
    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] r_hi, r_lo;
    logic [DATA_W-1:0] w_md_hi, w_md_lo;
    logic              w_md_done;
    md_state_e         w_md_state;

    md_iter_unit #(.DATA_W(DATA_W)) u_md (
        .clk     (clk),
        .rst     (rst),
        .i_start (md_start),
        .i_op    (md_op_e'(md_op)),
        .i_a     (md_a),
        .i_b     (md_b),
        .o_hi    (w_md_hi),
        .o_lo    (w_md_lo),
        .o_state (w_md_state)
    );

    assign md_busy   = (w_md_state != IDLE);
    assign w_md_done = (w_md_state == FIX);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    assign rs_data  = (rs_addr == '0) ? '0 :
                      (wr_en && (wr_addr == rs_addr)) ? wr_data : r_regs[rs_addr];
    assign rt_data  = (rt_addr == '0) ? '0 :
                      (wr_en && (wr_addr == rt_addr)) ? wr_data : r_regs[rt_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];

    // A finishing operation owns HI/LO; moves are dropped while busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_md_done) begin
            r_hi <= w_md_hi;
            r_lo <= w_md_lo;
        end else if (hilo_we && !md_busy) begin
            if (hilo_sel) r_hi <= wr_data;
            else          r_lo <= wr_data;
        end
    end

    assign hi_out = r_hi;
    assign lo_out = r_lo;

endmodule
